// File: rtl/dv_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
// The optional grant timeout is enabled with the DV_ARB_TIMEOUT_EN macro.
package dv_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 16;

endpackage : dv_arb_pkg

// File: rtl/dv_pending_flag.sv
// Single pending-request flag: set pulse raises it, clear pulse drops it,
// and clear wins when both arrive together.
module dv_pending_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (clr_i) begin
            flag_d = 1'b0;
        end else if (set_i) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule : dv_pending_flag

// File: rtl/dv_rr_arbiter.sv
// Round-robin arbiter over NREQ pending flags with a registered grant.
// Define DV_ARB_TIMEOUT_EN to add the grant-wait timeout and timeout_err.
module dv_rr_arbiter
    import dv_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_set,
    input  logic [NREQ-1:0]          req_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [NREQ-1:0]          grant_oh,
    output logic [NREQ-1:0]          pending
`ifdef DV_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int IDW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [NREQ-1:0] goh_q, goh_d;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] done_oh;
    logic [NREQ-1:0] clr_eff;
    logic [IDW-1:0]  sel_id;
    logic            sel_found;

`ifdef DV_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          terr_q, terr_d;
`endif

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // A finishing grant clears its flag unless a fresh set re-arms it in the same cycle.
    assign clr_eff = req_clr | (done_oh & ~req_set);

    for (genvar i = 0; i < NREQ; i++) begin : g_flag
        dv_pending_flag u_flag (
            .clk    (clk),
            .rst_n  (rst_n),
            .set_i  (req_set[i]),
            .clr_i  (clr_eff[i]),
            .flag_o (pend[i])
        );
    end

    always_comb begin : search
        int j;
        sel_id    = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j -= NREQ;
            if (!sel_found && pend[j[IDW-1:0]]) begin
                sel_id    = j[IDW-1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        goh_d   = goh_q;
        rr_d    = rr_q;
        done_oh = '0;
`ifdef DV_ARB_TIMEOUT_EN
        wait_d  = wait_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    gid_d   = sel_id;
                    goh_d   = NREQ'(1) << sel_id;
`ifdef DV_ARB_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (out_ready) begin
                    done_oh = goh_q;
                    rr_d    = next_ptr(gid_q);
                    state_d = IDLE;
                end else if (req_clr[gid_q]) begin
                    // Withdrawn before acceptance: drop the grant, pointer stays put.
                    state_d = IDLE;
`ifdef DV_ARB_TIMEOUT_EN
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    done_oh = goh_q;
                    rr_d    = next_ptr(gid_q);
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    wait_d  = wait_q + 1'b1;
`endif
                end
                if (state_d == IDLE) begin
                    gid_d = '0;
                    goh_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gid_d   = '0;
                goh_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            goh_q   <= '0;
            rr_q    <= '0;
`ifdef DV_ARB_TIMEOUT_EN
            wait_q  <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            goh_q   <= goh_d;
            rr_q    <= rr_d;
`ifdef DV_ARB_TIMEOUT_EN
            wait_q  <= wait_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign out_valid = (state_q == GRANT);
    assign grant_id  = gid_q;
    assign grant_oh  = goh_q;
    assign pending   = pend;
`ifdef DV_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

endmodule : dv_rr_arbiter

// File: tb/tb_dv_rr_arbiter.sv
// Self-checking bench for dv_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_dv_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req_set = '0;
    logic [NREQ-1:0] req_clr = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [1:0]      grant_id;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] pending;
`ifdef DV_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    always #5 clk = ~clk;

    dv_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_set     (req_set),
        .req_clr     (req_clr),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .grant_id    (grant_id),
        .grant_oh    (grant_oh),
        .pending     (pending)
`ifdef DV_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a busy flag with the granted index, the next-search
    // start index, a wait count and a plain array of pending bits.
    bit m_busy;
    int m_gid;
    int m_rr;
    int m_wait;
    bit m_terr;
    bit m_pend[NREQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] m_pend_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_rr = 0; m_wait = 0; m_terr = 0;
        for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] s, input logic [NREQ-1:0] c, input logic rdy);
        bit n_busy;
        int n_gid, n_rr, n_wait;
        bit finished;
        n_busy = m_busy; n_gid = m_gid; n_rr = m_rr; n_wait = m_wait;
        finished = 0;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_rr + k) % NREQ;
                if (!n_busy && m_pend[idx]) begin
                    n_busy = 1; n_gid = idx; n_wait = 0;
                end
            end
        end else if (rdy) begin
            finished = 1; n_busy = 0; n_rr = (m_gid + 1) % NREQ;
        end else if (c[m_gid]) begin
            n_busy = 0;
`ifdef DV_ARB_TIMEOUT_EN
        end else if (m_wait == TIMEOUT - 1) begin
            finished = 1; n_busy = 0; n_rr = (m_gid + 1) % NREQ; m_terr = 1;
        end else begin
            n_wait = m_wait + 1;
`endif
        end
        for (int i = 0; i < NREQ; i++) begin
            if (c[i]) m_pend[i] = 0;
            else if (s[i]) m_pend[i] = 1;
            else if (finished && i == m_gid) m_pend[i] = 0;
        end
        m_busy = n_busy; m_gid = n_gid; m_rr = n_rr; m_wait = n_wait;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
        check_eq({tag, ".gid"}, 32'(grant_id), m_busy ? 32'(m_gid) : 32'd0);
        check_eq({tag, ".goh"}, 32'(grant_oh), m_busy ? (32'd1 << m_gid) : 32'd0);
        check_eq({tag, ".pend"}, 32'(pending), 32'(m_pend_vec()));
`ifdef DV_ARB_TIMEOUT_EN
        check_eq({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
`endif
    endtask

    task automatic drive(input logic [NREQ-1:0] s, input logic [NREQ-1:0] c, input logic rdy);
        req_set = s; req_clr = c; out_ready = rdy;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step(req_set, req_clr, out_ready);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int order[$];

    initial begin
        model_reset();
        do_reset();

        // Single request from requester 2
        drive(4'b0100, '0, 1'b1); step("single.set");
        drive('0, '0, 1'b1);      step("single.grant");
        check_eq("single.gid", 32'(grant_id), 32'd2);
        check_eq("single.goh", 32'(grant_oh), 32'h4);
        step("single.done");
        check_eq("single.pend2", 32'(pending[2]), 32'd0);

        // All four request: order 0,1,2,3 then pointer back at 0
        do_reset();
        drive(4'b1111, '0, 1'b1); step("rr.set");
        drive('0, '0, 1'b1);
        for (int n = 0; n < 9; n++) begin
            step("rr.run");
            if (out_valid) order.push_back(int'(grant_id));
        end
        check_eq("rr.count", 32'(order.size()), 32'd4);
        for (int n = 0; n < 4 && n < order.size(); n++) check_eq("rr.order", 32'(order[n]), 32'(n));
        drive(4'b1111, '0, 1'b1); step("rr.reset");
        drive('0, '0, 1'b1);      step("rr.regrant");
        check_eq("rr.wrap", 32'(grant_id), 32'd0);

        // Backpressure on requester 1
        do_reset();
        drive(4'b0010, '0, 1'b0); step("bp.set");
        drive('0, '0, 1'b0);      step("bp.grant");
        for (int n = 0; n < 5; n++) begin
            step("bp.hold");
            check_eq("bp.stable", {31'd0, out_valid} | (32'(grant_id) << 4), 32'h11);
        end
        drive('0, '0, 1'b1); step("bp.accept");
        check_eq("bp.after", 32'(out_valid), 32'd0);

        // Withdraw during grant of 1; pointer must stay at 0 so 1 wins over 3
        do_reset();
        drive(4'b0010, '0, 1'b0); step("wd.set");
        drive('0, '0, 1'b0);      step("wd.grant");
        drive('0, 4'b0010, 1'b0); step("wd.clr");
        check_eq("wd.drop", 32'(out_valid), 32'd0);
        drive(4'b1010, '0, 1'b0); step("wd.reset");
        drive('0, '0, 1'b0);      step("wd.regrant");
        check_eq("wd.rr", 32'(grant_id), 32'd1);
        drive(4'b1000, 4'b1000, 1'b0); step("wd.setclr");
        check_eq("wd.p3", 32'(pending[3]), 32'd0);

        // Reset while a grant is presented
        do_reset();
        drive(4'b0001, '0, 1'b0); step("rg.set");
        drive('0, '0, 1'b0);      step("rg.grant");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rg.valid", 32'(out_valid), 32'd0);
        check_eq("rg.outs", 32'(grant_oh) | 32'(grant_id) | 32'(pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) step("rg.idle");

`ifdef DV_ARB_TIMEOUT_EN
        // Grant to 2 held off until the wait limit, then 3 is served
        do_reset();
        drive(4'b1100, '0, 1'b0); step("to.set");
        drive('0, '0, 1'b0);      step("to.grant");
        for (int n = 0; n < TIMEOUT - 1; n++) step("to.wait");
        step("to.abort");
        check_eq("to.err", 32'(timeout_err), 32'd1);
        step("to.next");
        check_eq("to.next_gid", 32'(grant_id), 32'd3);
        drive('0, '0, 1'b1); step("to.sticky");
        check_eq("to.sticky", 32'(timeout_err), 32'd1);
`endif

        // Random traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [NREQ-1:0] s, c;
            s = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            c = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
            drive(s, c, $urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dv_rr_arbiter

// File: doc/dv_rr_arbiter.md
DV_RR_ARBITER -- requirements
Module: dv_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum grant wait in cycles (used only with DV_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_set, input, NREQ bits: per-requester pulse that marks a request pending.
REQ-006 SHALL have port req_clr, input, NREQ bits: per-requester pulse that withdraws a pending request.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts the granted transfer.
REQ-008 SHALL have port out_valid, output, 1 bit: a grant is presented.
REQ-009 SHALL have port grant_id, output, $clog2(NREQ) bits: index of the granted requester; 0 when out_valid=0.
REQ-010 SHALL have port grant_oh, output, NREQ bits: one-hot grant; all zero when out_valid=0.
REQ-011 SHALL have port pending, output, NREQ bits: current per-requester pending flags.
REQ-012 SHALL have port timeout_err, output, 1 bit: sticky timeout flag; present only with DV_ARB_TIMEOUT_EN.

Function
REQ-013 SHALL keep one pending flag per requester. Set on req_set[i]; cleared on req_clr[i]. When both pulse in the same cycle, clear wins.
REQ-014 SHALL use a two-state FSM with states IDLE and GRANT.
REQ-015 IDLE: if any pending bit is 1 at the clock edge, SHALL go to GRANT, registering grant_id as the first pending index at or after rr_ptr, searching upward modulo NREQ.
REQ-016 GRANT: out_valid=1, and grant_id and grant_oh SHALL stay stable until the grant exits.
REQ-017 SHALL complete a transfer on out_valid && out_ready. On that edge: clear pending[grant_id], set rr_ptr to (grant_id+1) mod NREQ, and go to IDLE.
REQ-018 SHALL re-arm pending[grant_id] if req_set[grant_id] arrives in the completing cycle (the new request is not lost). req_clr in that cycle still wins.
REQ-019 If req_clr[grant_id] arrives during GRANT without out_ready, SHALL abort: go to IDLE, deassert out_valid next cycle, leave rr_ptr unchanged.
REQ-020 SHALL take at least one IDLE cycle between grants, giving a peak throughput of one grant per 2 cycles. Latency from req_set to out_valid is 2 cycles.
REQ-021 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-022 rr_ptr SHALL wrap from NREQ-1 to 0. With only one requester pending, it is re-granted repeatedly.

Reset
REQ-023 While rst_n=0, SHALL asynchronously force: state=IDLE, pending=0, rr_ptr=0, out_valid=0, grant_id=0, grant_oh=0, timeout_err=0.
REQ-024 Reset mid-GRANT SHALL drop the grant immediately, with no transfer counted. Operation resumes on the first edge after rst_n rises.

Configuration
REQ-025 With DV_ARB_TIMEOUT_EN defined:
- A wait counter SHALL clear on entering GRANT and increment each GRANT cycle without out_ready.
- On reaching TIMEOUT-1 it SHALL abort the grant: clear pending[grant_id], advance rr_ptr as for a transfer, go to IDLE, and set timeout_err.
- timeout_err stays set until reset.
REQ-026 Without DV_ARB_TIMEOUT_EN, SHALL omit the counter and the timeout_err port; a grant waits indefinitely.

Structure
REQ-027 Package dv_arb_pkg SHALL hold the FSM state typedef (IDLE, GRANT) and the NREQ and TIMEOUT default constants.
REQ-028 Sub-module dv_pending_flag SHALL implement one set/clear flag with clear priority and asynchronous active-low reset. It is instantiated NREQ times.

Verification
REQ-029 Single request: reset, req_set=4'b0100 for 1 cycle, out_ready=1 -> out_valid rises 2 cycles later with grant_id=2 and grant_oh=4'b0100; pending[2]=0 after the handshake.
REQ-030 Round-robin: req_set=4'b1111 held pending, out_ready=1 -> grant order 0,1,2,3, one grant per 2 cycles; rr_ptr returns to 0.
REQ-031 Backpressure: grant to 1 with out_ready=0 for 5 cycles -> grant_id=1 stable and out_valid=1 throughout; transfer on the first out_ready=1.
REQ-032 Withdraw: req_clr[1] during the GRANT of 1 -> out_valid=0 next cycle and rr_ptr unchanged. Simultaneous req_set[3] and req_clr[3] -> pending[3] stays 0.
REQ-033 Reset mid-grant: rst_n=0 while out_valid=1 -> all outputs 0 immediately, and no grant after release until a new req_set.
REQ-034 With DV_ARB_TIMEOUT_EN and TIMEOUT=16: out_ready held 0 -> grant aborts after 16 GRANT cycles, timeout_err=1 sticky, and the next pending requester is granted.
